// File: rtl/ladybird_execute.sv
// Execute stage of the ladybird core: operand muxing, ALU, and a 2-entry
// in-order result buffer feeding writeback with valid/ready on both sides.

module ladybird_alu #(
   parameter int XLEN          = 32,
   parameter int SIMULATION    = 0,
   parameter int USE_FA_MODULE = 1
) (
   input  logic [2:0]      OPERATION,
   input  logic            ALTERNATE,
   input  logic [XLEN-1:0] SRC1,
   input  logic [XLEN-1:0] SRC2,
   output logic [XLEN-1:0] Q
);
   localparam int SHW = $clog2(XLEN);

   logic [XLEN-1:0]        src2_eff;
   logic [XLEN-1:0]        sum;
   logic [SHW-1:0]         shamt;
   logic signed [XLEN-1:0] sra_res;

   assign src2_eff = ALTERNATE ? ~SRC2 : SRC2;
   assign shamt    = SRC2[SHW-1:0];
   assign sra_res  = $signed(SRC1) >>> shamt;

   // Simulation builds use the behavioural adder for speed.
   generate
      if (USE_FA_MODULE != 0 && SIMULATION == 0) begin : g_ripple
         logic [XLEN-1:0] carry;
         assign carry[0] = ALTERNATE;
         for (genvar i = 0; i < XLEN; i++) begin : g_bit
            assign sum[i] = SRC1[i] ^ src2_eff[i] ^ carry[i];
            if (i < XLEN - 1) begin : g_carry
               assign carry[i+1] = (SRC1[i] & src2_eff[i]) | (carry[i] & (SRC1[i] ^ src2_eff[i]));
            end
         end
      end else begin : g_behav
         assign sum = SRC1 + src2_eff + {{(XLEN-1){1'b0}}, ALTERNATE};
      end
   endgenerate

   always_comb begin
      Q = '0;
      unique case (OPERATION)
         3'b000: Q = sum;
         3'b001: Q = SRC1 << shamt;
         3'b010: Q = {{(XLEN-1){1'b0}}, ($signed(SRC1) < $signed(SRC2))};
         3'b011: Q = {{(XLEN-1){1'b0}}, (SRC1 < SRC2)};
         3'b100: Q = SRC1 ^ SRC2;
         3'b101: Q = ALTERNATE ? $unsigned(sra_res) : (SRC1 >> shamt);
         3'b110: Q = SRC1 | SRC2;
         3'b111: Q = SRC1 & SRC2;
      endcase
   end
endmodule

module ladybird_execute #(
   parameter int SIMULATION    = 0,
   parameter int USE_FA_MODULE = 1,
   parameter int XLEN          = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            FLUSH,
   input  logic            I_VALID,
   output logic            I_READY,
   input  logic [2:0]      I_OPERATION,
   input  logic            I_ALTERNATE,
   input  logic [1:0]      I_SRC1_SEL,
   input  logic            I_SRC2_SEL,
   input  logic [XLEN-1:0] I_RS1,
   input  logic [XLEN-1:0] I_RS2,
   input  logic [XLEN-1:0] I_PC,
   input  logic [XLEN-1:0] I_IMM,
   input  logic [4:0]      I_RD,
   output logic            O_VALID,
   input  logic            O_READY,
   output logic [XLEN-1:0] O_RESULT,
   output logic [4:0]      O_RD,
   output logic            O_WE,
   output logic [31:0]     O_COUNT
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] res0_q, res0_d, res1_q, res1_d;
   logic [4:0]      rd0_q, rd0_d, rd1_q, rd1_d;
   logic            we0_q, we0_d, we1_q, we1_d;
   logic            i_ready_q, i_ready_d;
   logic            o_valid_q, o_valid_d;
   logic [31:0]     cnt_q, cnt_d;

   logic [XLEN-1:0] src1, src2, alu_q;
   logic            alu_alt, push, pop, we_new;

   always_comb begin
      unique case (I_SRC1_SEL)
         2'b00:   src1 = I_RS1;
         2'b01:   src1 = I_PC;
         default: src1 = '0;
      endcase
   end

   assign src2    = I_SRC2_SEL ? I_IMM : I_RS2;
   // Immediate adds never subtract; ALTERNATE stays live for srai.
   assign alu_alt = I_ALTERNATE & ~(I_SRC2_SEL & (I_OPERATION == 3'b000));

   ladybird_alu #(
      .XLEN          (XLEN),
      .SIMULATION    (SIMULATION),
      .USE_FA_MODULE (USE_FA_MODULE)
   ) u_alu (
      .OPERATION (I_OPERATION),
      .ALTERNATE (alu_alt),
      .SRC1      (src1),
      .SRC2      (src2),
      .Q         (alu_q)
   );

   assign push   = I_VALID & i_ready_q & ~FLUSH;
   assign pop    = o_valid_q & O_READY & ~FLUSH;
   assign we_new = (I_RD != 5'd0);

   always_comb begin
      state_d = state_q;
      res0_d  = res0_q;
      res1_d  = res1_q;
      rd0_d   = rd0_q;
      rd1_d   = rd1_q;
      we0_d   = we0_q;
      we1_d   = we1_q;
      cnt_d   = cnt_q + {31'd0, pop};
      unique case (state_q)
         EMPTY: if (push) begin
            res0_d  = alu_q;
            rd0_d   = I_RD;
            we0_d   = we_new;
            state_d = ONE;
         end
         ONE: begin
            if (push && pop) begin
               res0_d = alu_q;
               rd0_d  = I_RD;
               we0_d  = we_new;
            end else if (push) begin
               res1_d  = alu_q;
               rd1_d   = I_RD;
               we1_d   = we_new;
               state_d = FULL;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: if (pop) begin
            res0_d  = res1_q;
            rd0_d   = rd1_q;
            we0_d   = we1_q;
            state_d = ONE;
         end
         default: state_d = EMPTY;
      endcase
      if (FLUSH) state_d = EMPTY;
      i_ready_d = (state_d != FULL);
      o_valid_d = (state_d != EMPTY);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= EMPTY;
         res0_q    <= '0;
         res1_q    <= '0;
         rd0_q     <= '0;
         rd1_q     <= '0;
         we0_q     <= 1'b0;
         we1_q     <= 1'b0;
         i_ready_q <= 1'b1;
         o_valid_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         res0_q    <= res0_d;
         res1_q    <= res1_d;
         rd0_q     <= rd0_d;
         rd1_q     <= rd1_d;
         we0_q     <= we0_d;
         we1_q     <= we1_d;
         i_ready_q <= i_ready_d;
         o_valid_q <= o_valid_d;
         cnt_q     <= cnt_d;
      end
   end

   assign I_READY  = i_ready_q;
   assign O_VALID  = o_valid_q;
   assign O_RESULT = res0_q;
   assign O_RD     = rd0_q;
   assign O_WE     = we0_q;
   assign O_COUNT  = cnt_q;
endmodule

// File: tb/tb_ladybird_execute.sv
// Directed bench for ladybird_execute: operand select, ALU edge cases,
// backpressure ordering, streaming against a reference model, flush and reset.

module tb_ladybird_execute;
   logic        clk = 1'b0;
   logic        rst, FLUSH, I_VALID, I_READY, I_ALTERNATE, I_SRC2_SEL;
   logic [2:0]  I_OPERATION;
   logic [1:0]  I_SRC1_SEL;
   logic [31:0] I_RS1, I_RS2, I_PC, I_IMM;
   logic [4:0]  I_RD;
   logic        O_VALID, O_READY, O_WE;
   logic [31:0] O_RESULT, O_COUNT;
   logic [4:0]  O_RD;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_cnt;

   ladybird_execute dut (
      .clk(clk), .rst(rst), .FLUSH(FLUSH), .I_VALID(I_VALID), .I_READY(I_READY),
      .I_OPERATION(I_OPERATION), .I_ALTERNATE(I_ALTERNATE), .I_SRC1_SEL(I_SRC1_SEL),
      .I_SRC2_SEL(I_SRC2_SEL), .I_RS1(I_RS1), .I_RS2(I_RS2), .I_PC(I_PC), .I_IMM(I_IMM),
      .I_RD(I_RD), .O_VALID(O_VALID), .O_READY(O_READY), .O_RESULT(O_RESULT),
      .O_RD(O_RD), .O_WE(O_WE), .O_COUNT(O_COUNT)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic alt, input logic [1:0] s1,
                        input logic s2, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd);
      I_OPERATION = op; I_ALTERNATE = alt; I_SRC1_SEL = s1; I_SRC2_SEL = s2;
      I_RS1 = rs1; I_RS2 = rs2; I_PC = pc; I_IMM = imm; I_RD = rd;
   endtask

   function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic alt,
                                           input logic [1:0] s1, input logic s2,
                                           input logic [31:0] rs1, input logic [31:0] rs2,
                                           input logic [31:0] pc, input logic [31:0] imm);
      logic [31:0] a, b, r;
      logic signed [31:0] sa;
      a  = (s1 == 2'b00) ? rs1 : (s1 == 2'b01) ? pc : 32'd0;
      b  = s2 ? imm : rs2;
      sa = a;
      case (op)
         3'd0: r = (alt && !s2) ? a - b : a + b;
         3'd1: r = a << b[4:0];
         3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3: r = (a < b) ? 32'd1 : 32'd0;
         3'd4: r = a ^ b;
         3'd5: begin
            if (alt) r = sa >>> b[4:0];
            else     r = a >> b[4:0];
         end
         3'd6: r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

   // Offer one op with O_READY=1, check the head next cycle, then let it pop.
   task automatic run_one(input string tag, input logic [31:0] exp_res, input logic exp_we);
      O_READY = 1'b1;
      I_VALID = 1'b1;
      step();
      I_VALID = 1'b0;
      check({tag, "_valid"}, {31'd0, O_VALID}, 32'd1);
      check({tag, "_result"}, O_RESULT, exp_res);
      check({tag, "_we"}, {31'd0, O_WE}, {31'd0, exp_we});
      step();
      exp_cnt++;
      check({tag, "_count"}, O_COUNT, exp_cnt);
   endtask

   logic [31:0] exp_q[$];
   logic [4:0]  exp_rd_q[$];
   logic [4:0]  got_rd[$];
   logic [31:0] got_res[$];
   logic [2:0]  r_op;
   logic        r_alt, r_s2, acc;
   logic [1:0]  r_s1;
   logic [31:0] r_rs1, r_rs2, r_pc, r_imm;
   logic [4:0]  r_rd;

   initial begin
      rst = 1'b1; FLUSH = 1'b0; I_VALID = 1'b0; O_READY = 1'b0;
      drive(3'd0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
      exp_cnt = 32'd0;
      step();
      step();
      rst = 1'b0;
      check("rst_o_valid", {31'd0, O_VALID}, 32'd0);
      check("rst_i_ready", {31'd0, I_READY}, 32'd1);
      check("rst_o_count", O_COUNT, 32'd0);
      check("rst_o_result", O_RESULT, 32'd0);
      check("rst_o_rd", {27'd0, O_RD}, 32'd0);
      check("rst_o_we", {31'd0, O_WE}, 32'd0);

      // Basic add with the head held, then popped.
      drive(3'd0, 1'b0, 2'd0, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3);
      I_VALID = 1'b1;
      step();
      I_VALID = 1'b0;
      check("add_valid", {31'd0, O_VALID}, 32'd1);
      check("add_result", O_RESULT, 32'd12);
      check("add_rd", {27'd0, O_RD}, 32'd3);
      check("add_we", {31'd0, O_WE}, 32'd1);
      O_READY = 1'b1;
      step();
      exp_cnt++;
      check("add_pop_valid", {31'd0, O_VALID}, 32'd0);
      check("add_pop_count", O_COUNT, exp_cnt);

      drive(3'd0, 1'b0, 2'd1, 1'b1, 32'd0, 32'd0, 32'h100, 32'h1000, 5'd4);
      run_one("pc_imm", 32'h1100, 1'b1);
      drive(3'd0, 1'b0, 2'd2, 1'b1, 32'd9, 32'd0, 32'h100, 32'hABCDE000, 5'd5);
      run_one("zero_imm", 32'hABCDE000, 1'b1);
      drive(3'd0, 1'b1, 2'd0, 1'b0, 32'd3, 32'd5, 32'd0, 32'd0, 5'd6);
      run_one("sub", 32'hFFFFFFFE, 1'b1);
      drive(3'd0, 1'b1, 2'd0, 1'b1, 32'd3, 32'd0, 32'd0, 32'd5, 5'd7);
      run_one("imm_alt", 32'd8, 1'b1);
      drive(3'd0, 1'b0, 2'd0, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 5'd0);
      run_one("rd0", 32'd2, 1'b0);
      drive(3'd5, 1'b1, 2'd0, 1'b0, 32'h80000000, 32'd31, 32'd0, 32'd0, 5'd8);
      run_one("sra31", 32'hFFFFFFFF, 1'b1);
      drive(3'd3, 1'b0, 2'd0, 1'b0, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd9);
      run_one("sltu", 32'd1, 1'b1);
      drive(3'd5, 1'b1, 2'd0, 1'b1, 32'hF0000000, 32'd0, 32'd0, 32'd4, 5'd9);
      run_one("srai", 32'hFF000000, 1'b1);

      // Backpressure: three offers with writeback stalled.
      O_READY = 1'b0;
      drive(3'd0, 1'b0, 2'd0, 1'b0, 32'd10, 32'd0, 32'd0, 32'd0, 5'd1);
      I_VALID = 1'b1;
      step();
      drive(3'd0, 1'b0, 2'd0, 1'b0, 32'd20, 32'd0, 32'd0, 32'd0, 5'd2);
      step();
      check("bp_full_ready", {31'd0, I_READY}, 32'd0);
      drive(3'd0, 1'b0, 2'd0, 1'b0, 32'd30, 32'd0, 32'd0, 32'd0, 5'd3);
      step();
      check("bp_hold_ready", {31'd0, I_READY}, 32'd0);
      check("bp_hold_rd", {27'd0, O_RD}, 32'd1);
      O_READY = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (O_VALID) begin
            got_rd.push_back(O_RD);
            got_res.push_back(O_RESULT);
         end
         acc = I_VALID & I_READY;
         step();
         if (acc) I_VALID = 1'b0;
      end
      exp_cnt += 3;
      check("bp_n_out", got_rd.size(), 32'd3);
      for (int k = 0; k < 3 && k < got_rd.size(); k++) begin
         check("bp_order_rd", {27'd0, got_rd[k]}, k + 1);
         check("bp_order_res", got_res[k], (k + 1) * 10);
      end
      check("bp_count", O_COUNT, exp_cnt);

      // Streaming 100 back-to-back ops.
      O_READY = 1'b1;
      for (int i = 0; i < 100; i++) begin
         check("str_i_ready", {31'd0, I_READY}, 32'd1);
         r_op = 3'($urandom_range(0, 7)); r_alt = 1'($urandom);
         r_s1 = 2'($urandom); r_s2 = 1'($urandom);
         r_rs1 = $urandom; r_rs2 = $urandom; r_pc = $urandom; r_imm = $urandom;
         r_rd = 5'($urandom);
         if (i < 4) r_rs1 = 32'hFFFFFFFF;
         drive(r_op, r_alt, r_s1, r_s2, r_rs1, r_rs2, r_pc, r_imm, r_rd);
         exp_q.push_back(ref_alu(r_op, r_alt, r_s1, r_s2, r_rs1, r_rs2, r_pc, r_imm));
         exp_rd_q.push_back(r_rd);
         I_VALID = 1'b1;
         step();
         check("str_valid", {31'd0, O_VALID}, 32'd1);
         check("str_result", O_RESULT, exp_q.pop_front());
         check("str_rd", {27'd0, O_RD}, {27'd0, exp_rd_q.pop_front()});
      end
      I_VALID = 1'b0;
      step();
      exp_cnt += 100;
      check("str_count", O_COUNT, exp_cnt);
      check("str_drained", {31'd0, O_VALID}, 32'd0);

      // Flush with a full buffer and an input on offer.
      O_READY = 1'b0;
      drive(3'd0, 1'b0, 2'd0, 1'b0, 32'h44, 32'd0, 32'd0, 32'd0, 5'd4);
      I_VALID = 1'b1;
      step();
      drive(3'd0, 1'b0, 2'd0, 1'b0, 32'h55, 32'd0, 32'd0, 32'd0, 5'd5);
      step();
      check("fl_pre_ready", {31'd0, I_READY}, 32'd0);
      drive(3'd0, 1'b0, 2'd0, 1'b0, 32'h666, 32'd0, 32'd0, 32'd0, 5'd6);
      FLUSH = 1'b1;
      O_READY = 1'b1;
      step();
      FLUSH = 1'b0;
      I_VALID = 1'b0;
      check("fl_o_valid", {31'd0, O_VALID}, 32'd0);
      check("fl_i_ready", {31'd0, I_READY}, 32'd1);
      check("fl_count", O_COUNT, exp_cnt);
      for (int c = 0; c < 3; c++) begin
         step();
         check("fl_no_ghost", {31'd0, O_VALID}, 32'd0);
      end

      // Reset while full.
      O_READY = 1'b0;
      drive(3'd1, 1'b0, 2'd0, 1'b1, 32'd1, 32'd0, 32'd0, 32'd4, 5'd7);
      I_VALID = 1'b1;
      step();
      step();
      I_VALID = 1'b0;
      check("rf_pre_ready", {31'd0, I_READY}, 32'd0);
      check("rf_pre_result", O_RESULT, 32'd16);
      rst = 1'b1;
      O_READY = 1'b1;
      step();
      rst = 1'b0;
      O_READY = 1'b0;
      check("rf_o_valid", {31'd0, O_VALID}, 32'd0);
      check("rf_i_ready", {31'd0, I_READY}, 32'd1);
      check("rf_o_count", O_COUNT, 32'd0);
      check("rf_o_result", O_RESULT, 32'd0);
      check("rf_o_rd", {27'd0, O_RD}, 32'd0);
      check("rf_o_we", {31'd0, O_WE}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
